// File: rtl/tx_fifo_feeder.sv
// tx_fifo_feeder: circular byte FIFO plus send sequencer feeding the UART transmitter.
// Defining FEEDER_STATS_EN adds the tx_count frame counter output.
module tx_fifo_feeder #(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic                   tx_send,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   ovf_err,
  output logic                   to_err,
  input  logic                   err_clr
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]            tx_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic [AW:0] level_q;
  logic [AW:0] level_d;
  logic        full_q;
  logic        empty_q;
  logic        tx_send_q;
  logic [7:0]  tx_data_q;
  logic        ovf_q;
  logic        to_q;
  logic [19:0] cnt_q;
  logic        push;
  logic        pop;
  logic        timeout;
  logic        frame_end;

  // Push uses the registered full flag, so a pop in the same cycle never frees a slot.
  always_comb begin
    push      = wr_en && !full_q;
    pop       = (state_q == IDLE) && !empty_q;
    timeout   = (state_q == REQ) && !tx_active && (cnt_q == TO_LAST);
    frame_end = (state_q == BUSY) && !tx_active && tx_done;
    level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
      to_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      level_q <= level_d;
      full_q  <= (level_d == FULL_LVL);
      empty_q <= (level_d == '0);

      // A new error event in the same cycle as err_clr leaves the flag set.
      if (wr_en && full_q) ovf_q <= 1'b1;
      else if (err_clr)    ovf_q <= 1'b0;
      if (timeout)         to_q  <= 1'b1;
      else if (err_clr)    to_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q <= mem_q[rptr_q[AW-1:0]];
            rptr_q    <= rptr_q + (AW+1)'(1);
            cnt_q     <= '0;
            tx_send_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 20'd1;
          if (tx_active) begin
            tx_send_q <= 1'b0;
            state_q   <= BUSY;
          end else if (timeout) begin
            tx_send_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        BUSY: begin
          if (frame_end) state_q <= IDLE;
        end
        default: begin
          tx_send_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

`ifdef FEEDER_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       count_q <= '0;
    else if (frame_end) count_q <= count_q + 16'd1;
  end

  assign tx_count = count_q;
`endif

  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;
  assign tx_send = tx_send_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != IDLE) || !empty_q;
  assign ovf_err = ovf_q;
  assign to_err  = to_q;

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Testbench for tx_fifo_feeder: transmitter model on the falling edge, byte-order and level scoreboard.
module tb_tx_fifo_feeder;
  localparam int DEPTH = 16;
  localparam int TO    = 12;
  localparam int AW    = $clog2(DEPTH);

  logic          clock;
  logic          reset_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          tx_active;
  logic          tx_done;
  logic          tx_send;
  logic [7:0]    tx_data;
  logic          busy;
  logic          ovf_err;
  logic          to_err;
  logic          err_clr;
`ifdef FEEDER_STATS_EN
  logic [15:0]   tx_count;
`endif

  tx_fifo_feeder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .busy      (busy),
    .ovf_err   (ovf_err),
    .to_err    (to_err),
    .err_clr   (err_clr)
`ifdef FEEDER_STATS_EN
    ,
    .tx_count  (tx_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         checks;
  int         passes;
  logic [7:0] sent[$];
  logic [7:0] expq[$];
  int         xst;
  int         xcnt;
  int         act_delay;
  int         frame_len;
  int         stable_bad;
  bit         xmit_en;
  bit         rand_mode;
  logic [7:0] fbyte;

  // Transmitter model: reacts on the falling edge so the DUT sees stable inputs at the rising edge.
  initial begin
    tx_active  = 1'b0;
    tx_done    = 1'b0;
    xst        = 0;
    xcnt       = 0;
    stable_bad = 0;
    fbyte      = 8'h00;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        xst = 0; tx_active = 1'b0; tx_done = 1'b0;
      end else begin
        case (xst)
          0: begin
            tx_done = 1'b0;
            if (xmit_en && tx_send === 1'b1) begin
              fbyte = tx_data;
              xcnt  = 0;
              if (rand_mode) begin
                act_delay = $urandom_range(1, 4);
                frame_len = $urandom_range(1, 6);
              end
              xst = 1;
            end
          end
          1: begin
            xcnt++;
            if (tx_data !== fbyte) stable_bad++;
            if (xcnt >= act_delay) begin tx_active = 1'b1; xcnt = 0; xst = 2; end
          end
          2: begin
            xcnt++;
            if (tx_data !== fbyte) stable_bad++;
            if (xcnt >= frame_len) begin
              tx_active = 1'b0; tx_done = 1'b1; sent.push_back(fbyte); xst = 3;
            end
          end
          default: begin tx_done = 1'b0; xst = 0; end
        endcase
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got time limit want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; err_clr = 1'b0; xmit_en = 1'b0; rand_mode = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sent.delete();
    stable_bad = 0;
    tick();
  endtask

  task automatic test_reset();
    wr_en = 1'b0; wr_data = 8'h00; err_clr = 1'b0; reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (full !== 1'b0)    $display("FAIL rst_full got %b want 0", full);       else passes++;
    checks++; if (empty !== 1'b1)   $display("FAIL rst_empty got %b want 1", empty);     else passes++;
    checks++; if (level !== '0)     $display("FAIL rst_level got %0d want 0", level);    else passes++;
    checks++; if (tx_send !== 1'b0) $display("FAIL rst_send got %b want 0", tx_send);    else passes++;
    checks++; if (tx_data !== 8'h00) $display("FAIL rst_data got %h want 00", tx_data);  else passes++;
    checks++; if (busy !== 1'b0)    $display("FAIL rst_busy got %b want 0", busy);       else passes++;
    checks++; if (ovf_err !== 1'b0) $display("FAIL rst_ovf got %b want 0", ovf_err);     else passes++;
    checks++; if (to_err !== 1'b0)  $display("FAIL rst_to got %b want 0", to_err);       else passes++;
`ifdef FEEDER_STATS_EN
    checks++; if (tx_count !== 16'd0) $display("FAIL rst_count got %0d want 0", tx_count); else passes++;
`endif
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    xmit_en = 1'b1; act_delay = 3; frame_len = 20;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++; if (level !== 1)      $display("FAIL t1_level_e0 got %0d want 1", level);    else passes++;
    checks++; if (tx_send !== 1'b0) $display("FAIL t1_send_e0 got %b want 0", tx_send);    else passes++;
    checks++; if (busy !== 1'b1)    $display("FAIL t1_busy_e0 got %b want 1", busy);       else passes++;
    tick();
    checks++; if (tx_send !== 1'b1) $display("FAIL t1_send_e1 got %b want 1", tx_send);    else passes++;
    checks++; if (tx_data !== 8'hA5) $display("FAIL t1_data_e1 got %h want a5", tx_data);  else passes++;
    checks++; if (level !== 0)      $display("FAIL t1_level_e1 got %0d want 0", level);    else passes++;
    n = 0;
    while (tx_done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n >= 100) $display("FAIL t1_wait_done got timeout want frame end"); else passes++;
    tick();
    checks++; if (busy !== 1'b0)     $display("FAIL t1_busy_end got %b want 0", busy);     else passes++;
    checks++; if (tx_data !== 8'hA5) $display("FAIL t1_data_end got %h want a5", tx_data); else passes++;
    checks++; if (sent.size() != 1 || sent[0] !== 8'hA5)
      $display("FAIL t1_sent got %0d bytes want 1 byte a5", sent.size()); else passes++;
    checks++; if (stable_bad != 0) $display("FAIL t1_stable got %0d changes want 0", stable_bad); else passes++;
  endtask

  task automatic test_fill_order();
    int n;
    do_reset();
    xmit_en = 1'b1; act_delay = 1; frame_len = 60;
    wr_en = 1'b1; wr_data = 8'h00;
    tick();
    wr_en = 1'b0;
    n = 0;
    while (tx_active !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n >= 20) $display("FAIL t2_wait_active got timeout want tx_active"); else passes++;
    for (int i = 1; i <= DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    checks++; if (full !== 1'b1)    $display("FAIL t2_full got %b want 1", full);        else passes++;
    checks++; if (level !== DEPTH)  $display("FAIL t2_level got %0d want %0d", level, DEPTH); else passes++;
    checks++; if (ovf_err !== 1'b0) $display("FAIL t2_ovf_pre got %b want 0", ovf_err);  else passes++;
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    checks++; if (ovf_err !== 1'b1) $display("FAIL t2_ovf got %b want 1", ovf_err);      else passes++;
    checks++; if (level !== DEPTH)  $display("FAIL t2_level_ovf got %0d want %0d", level, DEPTH); else passes++;
    frame_len = 4;
    n = 0;
    while ((sent.size() < DEPTH + 1 || busy !== 1'b0) && n < 1000) begin tick(); n++; end
    checks++; if (n >= 1000) $display("FAIL t2_drain got timeout want empty"); else passes++;
    checks++; if (sent.size() != DEPTH + 1) $display("FAIL t2_count got %0d want %0d", sent.size(), DEPTH + 1); else passes++;
    for (int i = 0; i < sent.size() && i <= DEPTH; i++) begin
      checks++; if (sent[i] !== 8'(i)) $display("FAIL t2_order[%0d] got %h want %h", i, sent[i], 8'(i)); else passes++;
    end
    checks++; if (stable_bad != 0) $display("FAIL t2_stable got %0d changes want 0", stable_bad); else passes++;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    wr_en = 1'b1; wr_data = 8'hB1;
    tick();
    wr_data = 8'hB2;
    tick();
    wr_en = 1'b0;
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hB1)
      $display("FAIL t3_req1 got send=%b data=%h want 1 b1", tx_send, tx_data); else passes++;
    checks++; if (level !== 1) $display("FAIL t3_level1 got %0d want 1", level); else passes++;
    n = 0;
    while (tx_send === 1'b1 && n < 200) begin n++; tick(); end
    checks++; if (n != TO)          $display("FAIL t3_req_len got %0d want %0d", n, TO); else passes++;
    checks++; if (to_err !== 1'b1)  $display("FAIL t3_to got %b want 1", to_err);       else passes++;
    checks++; if (level !== 1)      $display("FAIL t3_level_idle got %0d want 1", level); else passes++;
    err_clr = 1'b1;
    tick();
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hB2)
      $display("FAIL t3_req2 got send=%b data=%h want 1 b2", tx_send, tx_data); else passes++;
    checks++; if (level !== 0)      $display("FAIL t3_level2 got %0d want 0", level);   else passes++;
    checks++; if (to_err !== 1'b0)  $display("FAIL t3_clr got %b want 0", to_err);      else passes++;
    n = 0;
    while (tx_send === 1'b1 && n < 200) begin n++; tick(); end
    checks++; if (n != TO)          $display("FAIL t3_req2_len got %0d want %0d", n, TO); else passes++;
    checks++; if (to_err !== 1'b1)  $display("FAIL t3_set_wins got %b want 1", to_err); else passes++;
    tick();
    err_clr = 1'b0;
    checks++; if (to_err !== 1'b0)  $display("FAIL t3_clr2 got %b want 0", to_err);     else passes++;
    checks++; if (busy !== 1'b0)    $display("FAIL t3_busy got %b want 0", busy);       else passes++;
  endtask

  task automatic test_push_pop();
    int n;
    do_reset();
    xmit_en = 1'b1; act_delay = 1; frame_len = 30;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    checks++; if (level !== 3) $display("FAIL t4_level3 got %0d want 3", level); else passes++;
    n = 0;
    while (tx_done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n >= 100) $display("FAIL t4_wait1 got timeout want frame end"); else passes++;
    wr_en = 1'b1; wr_data = 8'h44;
    tick();
    wr_en = 1'b0;
    checks++; if (level !== 3)       $display("FAIL t4_pushpop got %0d want 3", level);  else passes++;
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'h41)
      $display("FAIL t4_b2b got send=%b data=%h want 1 41", tx_send, tx_data); else passes++;
    for (int i = 0; i < 13; i++) begin
      wr_en = 1'b1; wr_data = 8'h45 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1 || level !== DEPTH)
      $display("FAIL t4_full got full=%b level=%0d want 1 %0d", full, level, DEPTH); else passes++;
    n = 0;
    while (tx_done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n >= 100) $display("FAIL t4_wait2 got timeout want frame end"); else passes++;
    wr_en = 1'b1; wr_data = 8'hEE; err_clr = 1'b1;
    tick();
    wr_en = 1'b0; err_clr = 1'b0;
    checks++; if (level !== DEPTH - 1) $display("FAIL t4_drop_level got %0d want %0d", level, DEPTH - 1); else passes++;
    checks++; if (ovf_err !== 1'b1)    $display("FAIL t4_ovf_set_wins got %b want 1", ovf_err); else passes++;
    checks++; if (tx_data !== 8'h42)   $display("FAIL t4_next got %h want 42", tx_data); else passes++;
    tick();
    checks++; if (ovf_err !== 1'b1)    $display("FAIL t4_ovf_sticky got %b want 1", ovf_err); else passes++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (ovf_err !== 1'b0)    $display("FAIL t4_ovf_clr got %b want 0", ovf_err); else passes++;
  endtask

  task automatic test_reset_mid();
    int n;
    int sends;
    do_reset();
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    n = 0;
    while (to_err !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n >= 50) $display("FAIL t5_wait_to got timeout want to_err"); else passes++;
    xmit_en = 1'b1; act_delay = 2; frame_len = 40;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h31 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    n = 0;
    while (tx_active !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (level !== 5) $display("FAIL t5_level5 got %0d want 5", level); else passes++;
    reset_n = 1'b0;
    #2;
    checks++; if (tx_send !== 1'b0) $display("FAIL t5_send got %b want 0", tx_send);   else passes++;
    checks++; if (level !== 0)      $display("FAIL t5_level got %0d want 0", level);   else passes++;
    checks++; if (busy !== 1'b0)    $display("FAIL t5_busy got %b want 0", busy);      else passes++;
    checks++; if (to_err !== 1'b0 || ovf_err !== 1'b0)
      $display("FAIL t5_err got to=%b ovf=%b want 0 0", to_err, ovf_err); else passes++;
    tick();
    reset_n = 1'b1;
    sends = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_send === 1'b1) sends++;
    end
    checks++; if (sends != 0)   $display("FAIL t5_no_send got %0d want 0", sends);    else passes++;
    checks++; if (empty !== 1'b1) $display("FAIL t5_empty got %b want 1", empty);     else passes++;
  endtask

  task automatic test_back_to_back();
    int  level_m;
    bit  prev_send;
    bit  acc;
    bit  ovf_exp;
    bit  done;
    do_reset();
    expq.delete();
    rand_mode = 1'b1; xmit_en = 1'b1;
    level_m = 0; prev_send = 1'b0; ovf_exp = 1'b0; done = 1'b0;
    for (int c = 0; c < 1500 && !done; c++) begin
      if (c < 300) begin
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_data = 8'($urandom_range(0, 255));
      end else begin
        wr_en = 1'b0;
      end
      acc = wr_en && (level_m != DEPTH);
      if (acc) expq.push_back(wr_data);
      else if (wr_en) ovf_exp = 1'b1;
      tick();
      if (acc) level_m++;
      if (tx_send === 1'b1 && !prev_send) level_m--;
      prev_send = (tx_send === 1'b1);
      checks++; if (level !== level_m) $display("FAIL t6_level[%0d] got %0d want %0d", c, level, level_m); else passes++;
      checks++; if (full !== (level_m == DEPTH)) $display("FAIL t6_full[%0d] got %b want %b", c, full, level_m == DEPTH); else passes++;
      if (c >= 300 && level_m == 0 && busy === 1'b0) done = 1'b1;
    end
    wr_en = 1'b0;
    rand_mode = 1'b0;
    checks++; if (!done) $display("FAIL t6_drain got timeout want idle"); else passes++;
    checks++; if (ovf_err !== ovf_exp) $display("FAIL t6_ovf got %b want %b", ovf_err, ovf_exp); else passes++;
    checks++; if (sent.size() != expq.size()) $display("FAIL t6_count got %0d want %0d", sent.size(), expq.size()); else passes++;
    for (int i = 0; i < sent.size() && i < expq.size(); i++) begin
      checks++; if (sent[i] !== expq[i]) $display("FAIL t6_order[%0d] got %h want %h", i, sent[i], expq[i]); else passes++;
    end
    checks++; if (stable_bad != 0) $display("FAIL t6_stable got %0d changes want 0", stable_bad); else passes++;
  endtask

`ifdef FEEDER_STATS_EN
  task automatic test_stats();
    int n;
    do_reset();
    xmit_en = 1'b1; act_delay = 1; frame_len = 3;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    n = 0;
    while ((sent.size() < 3 || busy !== 1'b0) && n < 200) begin tick(); n++; end
    checks++; if (tx_count !== 16'd3) $display("FAIL t7_count got %0d want 3", tx_count); else passes++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    checks++; if (tx_count !== 16'd3) $display("FAIL t7_count_clr got %0d want 3", tx_count); else passes++;
  endtask
`endif

  initial begin
    checks = 0; passes = 0;
    wr_en = 1'b0; wr_data = 8'h00; err_clr = 1'b0; reset_n = 1'b0;
    xmit_en = 1'b0; rand_mode = 1'b0; act_delay = 1; frame_len = 1;
    test_reset();
    test_single();
    test_fill_order();
    test_timeout();
    test_push_pop();
    test_reset_mid();
    test_back_to_back();
`ifdef FEEDER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
